fork_sched: RTL

Parametrised fork scheduler for the multicore threadbrain datapath, successor to the single-cycle fork enable logic. It decodes FORK instructions from the writeback stream and hands each spawned thread a free core with context {valid, ptr, pc}. Requests that find no free core wait in a FIFO instead of being lost. Cores return to the free pool when they report completion on `core_done`. The block sits between writeback and the per-core fetch enables.

---
 rtl/fork_sched.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/fork_sched.sv
// fork_sched: decodes FORK instructions from writeback and hands each spawned thread a free core,
// queueing requests while every core is busy. Define FORK_RR_EN for round-robin core selection.

// Per-core enable/context slot; one instance per core.
module fork_slot #(
    parameter int PTR_W = 16,
    parameter int PC_W  = 16,
    parameter bit BOOT  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  grant,
    input  logic                  done,
    input  logic [PTR_W-1:0]      ptr,
    input  logic [PC_W-1:0]       pc,
    output logic                  en,
    output logic                  start,
    output logic [PTR_W+PC_W:0]   cxt
);

    logic             vld_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PC_W-1:0]  pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en    <= BOOT;
            start <= 1'b0;
            vld_q <= 1'b0;
            ptr_q <= '0;
            pc_q  <= '0;
        end else begin
            start <= grant;
            if (grant) begin
                en    <= 1'b1;
                vld_q <= 1'b1;
                ptr_q <= ptr;
                pc_q  <= pc;
            end else if (done && en) begin
                // ptr/pc are left as-is so the last context stays observable
                en    <= 1'b0;
                vld_q <= 1'b0;
            end
        end
    end

    assign cxt = {vld_q, ptr_q, pc_q};

endmodule

module fork_sched #(
    parameter int              NCORES    = 4,
    parameter int              PTR_W     = 16,
    parameter int              PC_W      = 16,
    parameter int              QDEPTH    = 4,
    parameter logic [3:0]      FORK      = 4'h7,
    parameter logic [NCORES-1:0] BOOT_MASK = {{(NCORES-1){1'b0}}, 1'b1}
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ins_valid,
    input  logic [15:0]                       ins,
    input  logic [PTR_W-1:0]                  ptr,
    input  logic [NCORES-1:0]                 core_done,
    output logic [NCORES-1:0]                 core_ens,
    output logic [NCORES*(1+PTR_W+PC_W)-1:0]  fork_cxt,
    output logic [NCORES-1:0]                 core_start,
    output logic                              stall,
    output logic                              overflow
);

    localparam int CW = 1 + PTR_W + PC_W;
    localparam int AW = $clog2(QDEPTH);
    localparam int IW = $clog2(NCORES);
    localparam logic [AW:0] FULL   = (AW+1)'(QDEPTH);
    localparam logic [AW:0] STL_TH = (AW+1)'(QDEPTH - 1);

    typedef struct packed {
        logic [PTR_W-1:0] ptr;
        logic [PC_W-1:0]  pc;
    } req_t;

    // stage 0 register
    logic             s0_vld;
    logic [15:0]      s0_ins;
    logic [PTR_W-1:0] s0_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld <= 1'b0;
            s0_ins <= '0;
            s0_ptr <= '0;
        end else begin
            s0_vld <= ins_valid;
            s0_ins <= ins;
            s0_ptr <= ptr;
        end
    end

    logic is_fork;
    req_t new_req;

    assign is_fork    = s0_vld && (s0_ins[15:12] == FORK);
    assign new_req.ptr = s0_ptr;
    assign new_req.pc  = {{(PC_W-12){1'b0}}, s0_ins[11:0]};

    // pending-fork FIFO
    req_t          fifo_mem [QDEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          fifo_empty;

    assign fifo_empty = (count == '0);
    assign stall      = (count >= STL_TH);

    // core selection
    logic [NCORES-1:0] free;
    logic              sel_vld;
    logic [IW-1:0]     sel_idx;

    assign free = ~core_ens & ~core_done;

`ifdef FORK_RR_EN
    logic [IW-1:0] rr_ptr;
`endif

    always_comb begin
        int j;
        j       = 0;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NCORES; k++) begin
`ifdef FORK_RR_EN
            j = (int'(rr_ptr) + 1 + k) % NCORES;
`else
            j = k;
`endif
            if (!sel_vld && free[j]) begin
                sel_vld = 1'b1;
                sel_idx = IW'(j);
            end
        end
    end

    // the FIFO head always outranks the new FORK
    logic  grant_vld, pop, push_need, push, drop;
    req_t  grant_req;
    logic [NCORES-1:0] grant;

    assign grant_vld = sel_vld && (!fifo_empty || is_fork);
    assign pop       = sel_vld && !fifo_empty;
    assign push_need = is_fork && (!sel_vld || !fifo_empty);
    assign push      = push_need && (count != FULL);
    assign drop      = push_need && (count == FULL);
    assign grant_req = fifo_empty ? new_req : fifo_mem[rd_ptr];

    always_comb begin
        grant = '0;
        if (grant_vld) grant[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= new_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef FORK_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rr_ptr <= '0;
        else if (grant_vld) rr_ptr <= sel_idx;
    end
`endif

    logic [NCORES-1:0][CW-1:0] cxt_arr;

    for (genvar i = 0; i < NCORES; i++) begin : g_slot
        fork_slot #(
            .PTR_W (PTR_W),
            .PC_W  (PC_W),
            .BOOT  (BOOT_MASK[i])
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .grant (grant[i]),
            .done  (core_done[i]),
            .ptr   (grant_req.ptr),
            .pc    (grant_req.pc),
            .en    (core_ens[i]),
            .start (core_start[i]),
            .cxt   (cxt_arr[i])
        );
    end

    assign fork_cxt = cxt_arr;

endmodule
